model_matrix_stream_transmitter: RTL and testbench

//   Buffers a matrix and streams it row-major into the A-side of

---
 rtl/model_matrix_stream_transmitter.sv | 145 ++++++++++++++
 tb/tb_model_matrix_stream_transmitter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/model_matrix_stream_transmitter.sv
// Buffers a matrix and streams it row-major, one element per consumer request,
// with per-element and per-row strobes for the A-side of the matrix-vector product.
module model_matrix_stream_transmitter #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned MAX_I        = 4,
  parameter int unsigned MAX_J        = 4,
  parameter int unsigned INDEX_SIZE   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [DATA_SIZE-1:0]  size_i_in,
  input  logic [DATA_SIZE-1:0]  size_j_in,
  input  logic                  write_enable,
  input  logic [INDEX_SIZE-1:0] write_i,
  input  logic [INDEX_SIZE-1:0] write_j,
  input  logic [DATA_SIZE-1:0]  write_data,
  input  logic                  data_next,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  data_out_i_enable,
  output logic                  data_out_j_enable
);

  localparam int unsigned RowW = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int unsigned ColW = (MAX_J > 1) ? $clog2(MAX_J) : 1;
  localparam logic [INDEX_SIZE:0] IdxOne = 1;
  localparam logic [DATA_SIZE-1:0] SizeOne = 1;

  // CONTROL_SIZE exists only for parameter-list compatibility across the codebase.
  if (CONTROL_SIZE == 0) begin : g_no_control
  end

  typedef enum logic [1:0] {StStarter, StOutput, StWait} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_SIZE:0]    i_q, i_d, j_q, j_d;
  logic [DATA_SIZE-1:0]   si_q, si_d, sj_q, sj_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   en_i_q, en_i_d, en_j_q, en_j_d;
  logic [DATA_SIZE-1:0]   buffer_q [MAX_I][MAX_J];

  logic bad_size, row_last, col_last, write_ok;

  assign bad_size = (size_i_in == '0) || (size_j_in == '0) ||
                    (size_i_in > DATA_SIZE'(MAX_I)) || (size_j_in > DATA_SIZE'(MAX_J));
  assign row_last = DATA_SIZE'(i_q) == (si_q - SizeOne);
  assign col_last = DATA_SIZE'(j_q) == (sj_q - SizeOne);
  assign write_ok = write_enable && (32'(write_i) < MAX_I) && (32'(write_j) < MAX_J);

  // Reads see the pre-edge contents, so a same-edge write lands after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(MAX_I); r++) begin
        for (int c = 0; c < int'(MAX_J); c++) begin
          buffer_q[r][c] <= '0;
        end
      end
    end else if (write_ok) begin
      buffer_q[write_i[RowW-1:0]][write_j[ColW-1:0]] <= write_data;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    data_d  = data_q;
    ready_d = 1'b0;
    en_i_d  = 1'b0;
    en_j_d  = 1'b0;
    unique case (state_q)
      StStarter: begin
        if (start) begin
          si_d = size_i_in;
          sj_d = size_j_in;
          i_d  = '0;
          j_d  = '0;
          if (bad_size) begin
            ready_d = 1'b1;
          end else begin
            state_d = StOutput;
          end
        end
      end
      StOutput: begin
        data_d  = buffer_q[i_q[RowW-1:0]][j_q[ColW-1:0]];
        en_j_d  = 1'b1;
        en_i_d  = (j_q == '0);
        state_d = StWait;
      end
      StWait: begin
        if (data_next) begin
          if (row_last && col_last) begin
            ready_d = 1'b1;
            state_d = StStarter;
          end else begin
            if (col_last) begin
              j_d = '0;
              i_d = i_q + IdxOne;
            end else begin
              j_d = j_q + IdxOne;
            end
            state_d = StOutput;
          end
        end
      end
      default: state_d = StStarter;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStarter;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      en_i_q  <= 1'b0;
      en_j_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      en_i_q  <= en_i_d;
      en_j_q  <= en_j_d;
    end
  end

  assign ready             = ready_q;
  assign data_out          = data_q;
  assign data_out_i_enable = en_i_q;
  assign data_out_j_enable = en_j_q;

endmodule

// File: tb/tb_model_matrix_stream_transmitter.sv
// Self-checking bench: table of stream scenarios plus randomized loads and sizes,
// each element compared against a plain array model of the matrix buffer.
module tb_model_matrix_stream_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [63:0] size_i_in, size_j_in;
  logic        write_enable;
  logic [2:0]  write_i, write_j;
  logic [63:0] write_data;
  logic        data_next;
  logic [63:0] data_out;
  logic        data_out_i_enable, data_out_j_enable;

  model_matrix_stream_transmitter #(
    .DATA_SIZE(64), .CONTROL_SIZE(4), .MAX_I(4), .MAX_J(4), .INDEX_SIZE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .size_i_in(size_i_in), .size_j_in(size_j_in),
    .write_enable(write_enable), .write_i(write_i), .write_j(write_j),
    .write_data(write_data), .data_next(data_next), .data_out(data_out),
    .data_out_i_enable(data_out_i_enable), .data_out_j_enable(data_out_j_enable)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] model_buf [4][4];

  typedef struct {
    int si; int sj; int gap; int mode; int fill; int exp_el; int exp_ip;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input int j, input logic [63:0] d);
    write_enable = 1'b1;
    write_i = 3'(i);
    write_j = 3'(j);
    write_data = d;
    tick();
    write_enable = 1'b0;
    if (i < 4 && j < 4) model_buf[i][j] = d;
  endtask

  // mode bits: 1 START mid-stream, 2 write [0][0] mid-stream,
  // 4 write each cell on the edge it is read, 8 reset after third element
  task automatic run_stream(input int si, input int sj, input int gap, input int mode,
                            output int n_el, output int n_ip);
    bit valid;
    logic [63:0] held, exp_d;
    valid = si >= 1 && si <= 4 && sj >= 1 && sj <= 4;
    n_el = 0;
    n_ip = 0;
    start = 1'b1;
    size_i_in = 64'(si);
    size_j_in = 64'(sj);
    tick();
    start = 1'b0;
    if (!valid) begin
      chk("bad_size_ready", ready, 1);
      chk("bad_size_no_enable", data_out_j_enable, 0);
      tick();
      chk("bad_size_ready_clear", ready, 0);
      return;
    end
    for (int i = 0; i < si; i++) begin
      for (int j = 0; j < sj; j++) begin
        exp_d = model_buf[i][j];
        if ((mode & 4) != 0) begin
          write_enable = 1'b1;
          write_i = 3'(i);
          write_j = 3'(j);
          write_data = ~exp_d;
        end
        tick();
        if ((mode & 4) != 0) begin
          write_enable = 1'b0;
          model_buf[i][j] = ~exp_d;
        end
        chk("j_enable", data_out_j_enable, 1);
        chk("i_enable", data_out_i_enable, (j == 0) ? 1 : 0);
        chk("data", data_out, exp_d);
        chk("ready_mid", ready, 0);
        n_el++;
        if (data_out_i_enable) n_ip++;
        if ((mode & 8) != 0 && n_el == 3) begin
          rst_n = 1'b0;
          #1;
          chk("abort_data", data_out, 0);
          chk("abort_enables", {data_out_i_enable, data_out_j_enable}, 0);
          chk("abort_ready", ready, 0);
          for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) model_buf[r][c] = '0;
          tick();
          rst_n = 1'b1;
          tick();
          chk("abort_no_ready", ready, 0);
          return;
        end
        held = data_out;
        for (int g = 0; g < gap; g++) begin
          if (g == 0 && n_el == 1 && (mode & 1) != 0) begin
            start = 1'b1;
            size_i_in = 64'd1;
            size_j_in = 64'd1;
          end
          if (g == 0 && n_el == 1 && (mode & 2) != 0) begin
            write_enable = 1'b1;
            write_i = 3'd0;
            write_j = 3'd0;
            write_data = 64'hA5A5_0000_0000_0077;
          end
          tick();
          if (g == 0 && n_el == 1 && (mode & 2) != 0) model_buf[0][0] = 64'hA5A5_0000_0000_0077;
          start = 1'b0;
          write_enable = 1'b0;
          chk("wait_no_enable", {data_out_i_enable, data_out_j_enable}, 0);
          chk("wait_data_stable", data_out, held);
        end
        data_next = 1'b1;
        tick();
        data_next = 1'b0;
        chk("pulse_one_cycle", data_out_j_enable, 0);
        if (i == si - 1 && j == sj - 1) begin
          chk("ready_pulse", ready, 1);
          tick();
          chk("ready_clear", ready, 0);
          chk("data_held_after", data_out, held);
        end
      end
    end
  endtask

  initial begin
    int n_el, n_ip, si, sj;
    rst_n = 1'b0;
    start = 1'b0;
    size_i_in = '0;
    size_j_in = '0;
    write_enable = 1'b0;
    write_i = '0;
    write_j = '0;
    write_data = '0;
    data_next = 1'b0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) model_buf[r][c] = '0;
    #2;
    chk("reset_data", data_out, 0);
    chk("reset_ready", ready, 0);
    chk("reset_enables", {data_out_i_enable, data_out_j_enable}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_stream(1, 1, 0, 0, n_el, n_ip);
    chk("cleared_buffer_count", 64'(n_el), 1);

    tbl[0]  = '{2, 3, 0, 0, 1, 6, 2};
    tbl[1]  = '{2, 3, 5, 0, 0, 6, 2};
    tbl[2]  = '{0, 3, 0, 0, 0, 0, 0};
    tbl[3]  = '{5, 3, 0, 0, 0, 0, 0};
    tbl[4]  = '{2, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 5, 0, 0, 0, 0, 0};
    tbl[6]  = '{2, 3, 2, 3, 0, 6, 2};
    tbl[7]  = '{1, 1, 0, 0, 0, 1, 1};
    tbl[8]  = '{2, 2, 1, 4, 0, 4, 2};
    tbl[9]  = '{4, 4, 0, 0, 2, 16, 4};
    tbl[10] = '{3, 3, 1, 8, 0, 3, 1};
    tbl[11] = '{2, 2, 0, 0, 0, 4, 2};

    for (int t = 0; t < 12; t++) begin
      if (tbl[t].fill == 1) begin
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) wr(i, j, 64'(i * 3 + j + 1));
      end else if (tbl[t].fill == 2) begin
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wr(i, j, 64'(100 + 4 * i + j));
        wr(4, 0, 64'hDEAD);
        wr(0, 4, 64'hBEEF);
      end
      run_stream(tbl[t].si, tbl[t].sj, tbl[t].gap, tbl[t].mode, n_el, n_ip);
      chk($sformatf("vec%0d_elements", t), 64'(n_el), 64'(tbl[t].exp_el));
      chk($sformatf("vec%0d_row_pulses", t), 64'(n_ip), 64'(tbl[t].exp_ip));
    end

    for (int k = 0; k < 25; k++) begin
      for (int w = 0; w < 3; w++) begin
        wr(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), {$urandom, $urandom});
      end
      si = int'($urandom_range(0, 5));
      sj = int'($urandom_range(0, 5));
      run_stream(si, sj, int'($urandom_range(0, 2)), 0, n_el, n_ip);
      if (si >= 1 && si <= 4 && sj >= 1 && sj <= 4) begin
        chk("rand_elements", 64'(n_el), 64'(si * sj));
        chk("rand_row_pulses", 64'(n_ip), 64'(si));
      end else begin
        chk("rand_rejected", 64'(n_el), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
